// File: rtl/imem_loader_if.sv
// Byte-stream receive and instruction-memory write bundle for imem_loader.
// Signals: rx_data/rx_valid/rx_ready byte handshake, mem_we/mem_addr/mem_wdata write port.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a 16-bit word count then big-endian words from a byte
// stream and writes them to instruction memory while holding the fetch stage.
// Ports: clk, rst (sync, active-high), start, bus (slave), cpu_hold,
//        load_done, load_err.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00000000,
  parameter logic [31:0] ADDR_INC  = 32'h00000004,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        rdy;
  logic        acc;
  logic [15:0] hdr;

  assign rdy = (state_q == HDR_HI) ||
               (state_q == HDR_LO) ||
               (state_q == DATA);
  assign acc = rdy && bus.rx_valid;
  assign hdr = {cnt_q[15:8], bus.rx_data};

  assign bus.rx_ready  = rdy;
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = rdy || (state_q == WRITE);
  // DONE is only left by start or rst, so the flag is the state itself.
  assign load_done     = (state_q == DONE);
  assign load_err      = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HDR_HI;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      HDR_HI: begin
        if (acc) begin
          cnt_d[15:8] = bus.rx_data;
          state_d     = HDR_LO;
        end
      end
      HDR_LO: begin
        if (acc) begin
          cnt_d = hdr;
          if (hdr == 16'd0) begin
            state_d = DONE;
          end else if (hdr > MAX_WORDS) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
            addr_d  = BASE_ADDR;
            rem_d   = hdr;
            idx_d   = 2'd0;
          end
        end
      end
      DATA: begin
        if (acc) begin
          unique case (idx_q)
            2'd0: wdata_d[31:24] = bus.rx_data;
            2'd1: wdata_d[23:16] = bus.rx_data;
            2'd2: wdata_d[15:8]  = bus.rx_data;
            2'd3: wdata_d[7:0]   = bus.rx_data;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_INC;
        rem_d  = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00000000, meaning the instruction-memory address of the first loaded word.
REQ-002 The block SHALL have parameter ADDR_INC, default 32'h00000004, meaning the address step per word, matching the fetch-stage PC increment.
REQ-003 The block SHALL have parameter MAX_WORDS, default 16'd1024, meaning the largest legal word count.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  meaning a request to begin a load.
REQ-007 The block SHALL have port rx_data  input  8  meaning the incoming byte.
REQ-008 The block SHALL have port rx_valid  input  1  meaning rx_data holds a valid byte.
REQ-009 The block SHALL have port rx_ready  output  1  meaning the block accepts a byte this cycle.
REQ-010 The block SHALL have port mem_we  output  1  meaning the instruction-memory write strobe.
REQ-011 The block SHALL have port mem_addr  output  32  meaning the instruction-memory write byte address.
REQ-012 The block SHALL have port mem_wdata  output  32  meaning the instruction word to write.
REQ-013 The block SHALL have port cpu_hold  output  1  meaning the fetch stage is frozen while high.
REQ-014 The block SHALL have port load_done  output  1  meaning the last load ended.
REQ-015 The block SHALL have port load_err  output  1  meaning the last load was rejected.

Function
REQ-016 A byte SHALL be accepted only on a rising edge where rx_valid=1 and rx_ready=1; otherwise rx_data is ignored.
REQ-017 The state machine SHALL have the states IDLE, HDR_HI, HDR_LO, DATA, WRITE and DONE.
REQ-018 In IDLE, start=1 SHALL move the state to HDR_HI and clear load_done and load_err.
REQ-019 In HDR_HI, rx_ready SHALL be 1, and an accepted byte SHALL become count[15:8] and move the state to HDR_LO.
REQ-020 In HDR_LO, rx_ready SHALL be 1, and an accepted byte SHALL become count[7:0].
REQ-021 On leaving HDR_LO, count=0 SHALL move the state to DONE with no writes.
REQ-022 On leaving HDR_LO, count>MAX_WORDS SHALL move the state to DONE with load_err=1 and no writes.
REQ-023 On leaving HDR_LO with any other count, the state SHALL move to DATA with mem_addr=BASE_ADDR, remaining=count and byte index=0.
REQ-024 In DATA, rx_ready SHALL be 1 and bytes SHALL assemble big-endian: first byte to [31:24], second to [23:16], third to [15:8], fourth to [7:0].
REQ-025 Acceptance of the fourth byte SHALL move the state to WRITE.
REQ-026 In WRITE, rx_ready=0 and mem_we=1 for exactly one cycle, with mem_addr and mem_wdata stable.
REQ-027 The write latency SHALL be one cycle: mem_we is high in the cycle immediately after the fourth byte is accepted.
REQ-028 On leaving WRITE, mem_addr SHALL advance by ADDR_INC (32-bit modulo, wrapping silently past 32'hFFFFFFFF) and remaining SHALL decrement.
REQ-029 On leaving WRITE, the state SHALL move to DONE if remaining reaches 0, otherwise to DATA.
REQ-030 mem_we SHALL be 0 in every state except WRITE.
REQ-031 rx_ready SHALL be 0 in IDLE, WRITE and DONE.
REQ-032 cpu_hold SHALL be 1 exactly in HDR_HI, HDR_LO, DATA and WRITE, decoded from the state register.
REQ-033 In DONE, load_done SHALL be 1 and held until rst or start.
REQ-034 start=1 in DONE SHALL behave as in IDLE: go to HDR_HI and clear the flags.
REQ-035 start SHALL be ignored in HDR_HI, HDR_LO, DATA and WRITE.
REQ-036 A stalled stream (rx_valid=0) SHALL hold all state indefinitely, with no timeout.

Reset
REQ-037 rst=1 at a rising edge SHALL force the state to IDLE, mem_addr=BASE_ADDR, and mem_wdata, count, remaining and byte index to 0.
REQ-038 rst=1 at a rising edge SHALL force rx_ready, mem_we, cpu_hold, load_done and load_err to 0.
REQ-039 rst SHALL take priority over start and byte acceptance in the same cycle.
REQ-040 rst mid-load SHALL discard any partial word with no write issued.

Verification
REQ-041 The bench SHALL cover: start, then bytes 00 02 12 34 56 78 9A BC DE F0 -> writes 32'h12345678 at 0x0 and 32'h9ABCDEF0 at 0x4, then load_done=1 and cpu_hold=0.
REQ-042 The bench SHALL cover: header 00 00 -> DONE with no mem_we, load_done=1, load_err=0.
REQ-043 The bench SHALL cover: header 04 01 with MAX_WORDS=1024 -> load_err=1, load_done=1, no mem_we.
REQ-044 The bench SHALL cover: rx_valid gaps of 0-5 cycles between bytes plus start pulses mid-load -> identical writes and addresses to the ungapped run.
REQ-045 The bench SHALL cover: rst after the 2nd data byte, then a fresh load of 1 word AABBCCDD -> single write of 32'hAABBCCDD at BASE_ADDR.
REQ-046 The bench SHALL cover: BASE_ADDR=32'hFFFFFFFC with 2 words -> writes at 0xFFFFFFFC then 0x00000000.
